// File: rtl/leg_solver.sv
// Iterative leg solver: B = floor(sqrt(H*H - A*A)), one bit-serial root step per cycle.
// start/busy/done handshake; err flags A > H and holds until the next accepted start.
module leg_solver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             start,
    input  logic [WIDTH-1:0] hyp_in,
    input  logic [WIDTH-1:0] leg_in,
    output logic [WIDTH-1:0] leg_out,
    output logic             done,
    output logic             busy,
    output logic             err
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DIFF, ROOT, FIN} state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   hyp_reg;
    logic [WIDTH-1:0]   leg_reg;
    logic [WIDTH-1:0]   root_reg;
    logic [2*WIDTH-1:0] diff_reg;
    logic [IW-1:0]      idx_reg;

    logic [WIDTH-1:0]   trial;
    logic [2*WIDTH-1:0] trial_sq;
    logic [2*WIDTH-1:0] hyp_sq;
    logic [2*WIDTH-1:0] leg_sq;
    logic               trial_fits;

    // Trial root: current partial root with the bit under test forced to one.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_trial
            assign trial[gi] = root_reg[gi] | (idx_reg == IW'(gi));
        end
    endgenerate

    // Zero-extended operands make every square a full 2*WIDTH-bit product.
    assign trial_sq   = {{WIDTH{1'b0}}, trial}   * {{WIDTH{1'b0}}, trial};
    assign hyp_sq     = {{WIDTH{1'b0}}, hyp_reg} * {{WIDTH{1'b0}}, hyp_reg};
    assign leg_sq     = {{WIDTH{1'b0}}, leg_reg} * {{WIDTH{1'b0}}, leg_reg};
    assign trial_fits = (trial_sq <= diff_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            hyp_reg   <= '0;
            leg_reg   <= '0;
            root_reg  <= '0;
            diff_reg  <= '0;
            idx_reg   <= '0;
            leg_out   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else if (ena) begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        hyp_reg   <= hyp_in;
                        leg_reg   <= leg_in;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        state_reg <= DIFF;
                    end
                end
                DIFF: begin
                    if (leg_reg > hyp_reg) begin
                        leg_out   <= '0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= FIN;
                    end else begin
                        diff_reg  <= hyp_sq - leg_sq;
                        root_reg  <= '0;
                        idx_reg   <= IW'(WIDTH - 1);
                        state_reg <= ROOT;
                    end
                end
                ROOT: begin
                    if (trial_fits) begin
                        root_reg <= trial;
                    end
                    if (idx_reg == '0) begin
                        leg_out   <= trial_fits ? trial : root_reg;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= FIN;
                    end else begin
                        idx_reg <= idx_reg - 1'b1;
                    end
                end
                FIN: begin
                    done      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_leg_solver.sv
// Directed-vector bench for leg_solver: results, latency, error flag, ignored starts,
// mid-operation reset and clock-enable stalling.
module tb_leg_solver;
    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             ena;
    logic             start;
    logic [WIDTH-1:0] hyp_in;
    logic [WIDTH-1:0] leg_in;
    logic [WIDTH-1:0] leg_out;
    logic             done;
    logic             busy;
    logic             err;

    int n_checks = 0;
    int n_errors = 0;

    leg_solver #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .start   (start),
        .hyp_in  (hyp_in),
        .leg_in  (leg_in),
        .leg_out (leg_out),
        .done    (done),
        .busy    (busy),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [WIDTH+2:0] outs = {leg_out, done, busy, err};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after the accepting edge E0.
    task automatic issue(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] a);
        hyp_in = h;
        leg_in = a;
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Counts edges after E0 until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] h, input logic [WIDTH-1:0] a,
                          input int exp_leg, input int exp_err, input int exp_lat);
        int n;
        issue(h, a);
        check("busy_after_accept", busy, 1);
        check("err_cleared", err, 0);
        wait_done(n);
        $display("op H=%0d A=%0d -> leg_out=%0d err=%0d latency=%0d", h, a, leg_out, err, n);
        check("latency", n, exp_lat);
        check("leg_out", leg_out, exp_leg);
        check("err", err, exp_err);
        check("busy_at_done", busy, 0);
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("leg_out_held", leg_out, exp_leg);
    endtask

    initial begin
        int n;
        int dones;
        int done_at;
        int en_edges;
        logic ena_n;
        logic [WIDTH+2:0] snap;

        rst = 1'b1; ena = 1'b1; start = 1'b0; hyp_in = '0; leg_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outs", outs, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'd5,   8'd3,   4,   0, 9);
        run_op(8'd13,  8'd5,   12,  0, 9);
        run_op(8'd10,  8'd1,   9,   0, 9);
        run_op(8'd255, 8'd0,   255, 0, 9);
        run_op(8'd10,  8'd10,  0,   0, 9);
        run_op(8'd3,   8'd5,   0,   1, 1);

        // err must persist through idle cycles until a new start is accepted.
        repeat (3) @(negedge clk);
        check("err_held_idle", err, 1);
        run_op(8'd5, 8'd3, 4, 0, 9);

        // Starts during ROOT and FIN are ignored; the following IDLE start is accepted.
        issue(8'd5, 8'd3);
        dones = 0;
        done_at = 0;
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) begin
                hyp_in = 8'd13; leg_in = 8'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                dones++;
                done_at = k;
            end
        end
        $display("op H=5 A=3 with stray starts -> leg_out=%0d dones=%0d at edge %0d", leg_out, dones, done_at);
        check("ignored_dones", dones, 1);
        check("ignored_done_at", done_at, 9);
        check("ignored_leg", leg_out, 4);
        hyp_in = 8'd13; leg_in = 8'd5; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("fin_start_ignored_busy", busy, 0);
        check("fin_start_ignored_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("idle_start_accepted", busy, 1);
        wait_done(n);
        $display("op H=13 A=5 after FIN -> leg_out=%0d latency=%0d", leg_out, n);
        check("idle_start_leg", leg_out, 12);
        check("idle_start_latency", n, 9);
        @(negedge clk);

        // Reset in the 4th ROOT cycle aborts without a done.
        issue(8'd5, 8'd3);
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        $display("op H=5 A=3 aborted by reset -> leg_out=%0d busy=%0d", leg_out, busy);
        check("abort_outs", outs, 0);
        dones = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

        // Clock enable toggling: outputs freeze on disabled edges, latency in enabled edges unchanged.
        issue(8'd13, 8'd12);
        en_edges = 0;
        ena_n = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            ena = ena_n;
            snap = outs;
            @(posedge clk);
            @(negedge clk);
            if (ena) en_edges++;
            else check("frozen", outs, snap);
            ena_n = !ena_n;
        end
        $display("op H=13 A=12 with ena toggling -> leg_out=%0d enabled_edges=%0d", leg_out, en_edges);
        check("ena_done", done, 1);
        check("ena_edges", en_edges, 9);
        check("ena_leg", leg_out, 5);
        ena = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("done_held_frozen", done, 1);
        ena = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("done_cleared", done, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/leg_solver.md
Name: leg_solver

Overview:
- Inverse of the hypotenuse block: given hypotenuse H and one leg A, computes the other leg B = floor(sqrt(H*H - A*A)).
- Iterative, multi-cycle engine with a start/busy/done handshake and one bit-serial square-root iteration per cycle.
- Sits beside the hypotenuse datapath in the same tile.
- Results round-trip: feeding (hypotenuse, leg) back recovers the other leg for Pythagorean triples.

Parameters:
- WIDTH, 8, operand and result width in bits; internal difference register is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- ena  input  1  clock enable; when low every register holds its value
- start  input  1  request pulse; sampled only in IDLE with ena high
- hyp_in  input  WIDTH  hypotenuse H, captured when start is accepted
- leg_in  input  WIDTH  known leg A, captured when start is accepted
- leg_out  output  WIDTH  computed leg B; held until the next completion or reset
- done  output  1  single-cycle completion strobe
- busy  output  1  high while a computation is in flight
- err  output  1  set with done when A > H; held until the next accepted start

Behaviour:
- Reset is synchronous, active-high, and has priority over ena:
  - state = IDLE
  - leg_out = 0, done = 0, busy = 0, err = 0
  - internal regs = 0
- Reset mid-operation aborts the computation; no done is issued.
- FSM states: IDLE, DIFF, ROOT, FIN. All transitions occur only on edges with ena = 1.
- IDLE, start = 1:
  - capture H and A; clear err
  - busy <= 1
  - go to DIFF
  - start in any other state is ignored, with no queuing.
- DIFF:
  - compute the 2*WIDTH-bit difference H*H - A*A.
  - If A > H: leg_out <= 0, err <= 1, go to FIN.
  - Else: diff_reg <= H*H - A*A, root <= 0, bit index <= WIDTH-1, go to ROOT.
- ROOT, one iteration per edge:
  - trial = root | (1 << idx)
  - if trial*trial <= diff_reg then root <= trial
  - idx decrements
- ROOT exit: after the idx = 0 iteration, leg_out <= final root and go to FIN.
- FIN:
  - done = 1 and busy = 0 for exactly this one cycle
  - next edge goes to IDLE
  - start presented during FIN is ignored.
- Latency, counting the accepting edge as E0 with ena continuously high:
  - normal case: done is visible after edge E(WIDTH+1), i.e. 9 edges for WIDTH = 8
  - error case: done is visible after E1.
- busy = 1 exactly in DIFF and ROOT.
- done and err are registered outputs. err stays high after FIN until the next accepted start or reset.
- Width rules:
  - squares are 2*WIDTH bits unsigned
  - the compare trial*trial uses a 2*WIDTH-bit product, which cannot overflow
  - the result always fits in WIDTH bits.
- A == H gives diff 0 and result 0, with err = 0.
- ena low mid-operation stalls all state, including holding done high if in FIN; the total latency in enabled cycles is unchanged.

Test Plan:
- H=5, A=3, start pulse -> busy for 9 cycles, then done=1 for one cycle with leg_out=4, err=0; same check for H=13, A=5 -> 12.
- Non-triple and extremes -> H=10, A=1 gives leg_out=9 (floor sqrt 99); H=255, A=0 gives 255; H=10, A=10 gives 0, err=0.
- H=3, A=5 -> done after 2 edges with err=1 and leg_out=0; err stays 1 until the next start, then clears on the edge that accepts it.
- Second start asserted during ROOT and again during FIN -> ignored; exactly one done with the first result; a start in the following IDLE cycle is accepted normally.
- rst pulsed in the 4th ROOT cycle -> next cycle state is IDLE, busy=0, leg_out=0, and no done appears for 20 cycles.
- ena toggled 1/0 every other cycle during H=13, A=12 -> leg_out=5 after 9 enabled edges; all outputs frozen on ena=0 cycles, done held while frozen in FIN.
